// File: rtl/multicycle_alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and shift-amount width for multicycle_alu.
package alu_pkg;
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_SRL   = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_LUI   = 4'b1000;
    localparam logic [3:0] OP_OR    = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_SLL   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_REMU  = 4'b1110;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    function automatic int shamt_w(input int dw);
        return $clog2(dw);
    endfunction
endpackage

// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: start/done operand and result bundle between control and ALU.
interface multicycle_alu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
);
    logic                  Start_i;
    logic [OP_WIDTH-1:0]   ALU_Operation_i;
    logic [DATA_WIDTH-1:0] A_i;
    logic [DATA_WIDTH-1:0] B_i;
    logic                  Busy_o;
    logic                  Done_o;
    logic                  Zero_o;
    logic [DATA_WIDTH-1:0] ALU_Result_o;

    modport master (
        output Start_i, ALU_Operation_i, A_i, B_i,
        input  Busy_o, Done_o, Zero_o, ALU_Result_o
    );
    modport slave (
        input  Start_i, ALU_Operation_i, A_i, B_i,
        output Busy_o, Done_o, Zero_o, ALU_Result_o
    );
endinterface

// File: rtl/multicycle_alu_iter.sv
// alu_iter_unit: one-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// {hi,lo} is the product (mul) or remainder/quotient (div); lo_o/hi_o are the post-step values.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  div_i,
    input  logic                  step_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  last_o,
    output logic [DATA_WIDTH-1:0] lo_o,
    output logic [DATA_WIDTH-1:0] hi_o
);
    localparam int CW = shamt_w(DATA_WIDTH) + 1;

    logic [CW-1:0]         cnt_q;
    logic                  div_q;
    logic [DATA_WIDTH-1:0] lo_q, hi_q, op_q;
    logic [DATA_WIDTH:0]   sum, rs, diff;

    always_comb begin
        sum    = {1'b0, hi_q} + {1'b0, op_q & {DATA_WIDTH{lo_q[0]}}};
        rs     = {hi_q, lo_q[DATA_WIDTH-1]};
        diff   = rs - {1'b0, op_q};
        lo_o   = div_q ? {lo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]} : {sum[0], lo_q[DATA_WIDTH-1:1]};
        hi_o   = div_q ? (diff[DATA_WIDTH] ? rs[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0]) : sum[DATA_WIDTH:1];
        last_o = cnt_q == CW'(DATA_WIDTH - 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            div_q <= 1'b0;
            lo_q  <= '0;
            hi_q  <= '0;
            op_q  <= '0;
        end else if (start_i) begin
            cnt_q <= '0;
            div_q <= div_i;
            lo_q  <= div_i ? a_i : b_i;
            hi_q  <= '0;
            op_q  <= div_i ? b_i : a_i;
        end else if (step_i) begin
            cnt_q <= last_o ? cnt_q : cnt_q + 1'b1;
            lo_q  <= lo_o;
            hi_q  <= hi_o;
        end
    end
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: RV32I ALU with start/done handshake; 1-cycle ops plus iterative MUL/DIV.
// Define ALU_MULDIV_EN to build the iterative MUL/MULHU/DIVU/REMU path; otherwise those opcodes return 0.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_alu_if.slave   bus
);
    localparam int SW = shamt_w(DATA_WIDTH);

    logic [3:0]            op;
    logic [DATA_WIDTH-1:0] a, b, one_res, res_d, res_q;
    logic [SW-1:0]         sh;
    logic                  wr, done_q, zero_q;

    assign op = bus.ALU_Operation_i[3:0];
    assign a  = bus.A_i;
    assign b  = bus.B_i;
    assign sh = b[SW-1:0];

    always_comb begin
        one_res = '0;
        case (op)
            OP_ADD:  one_res = a + b;
            OP_SUB:  one_res = a - b;
            OP_AND:  one_res = a & b;
            OP_SRL:  one_res = a >> sh;
            OP_XOR:  one_res = a ^ b;
            OP_SRA:  one_res = $signed(a) >>> sh;
            OP_SLT:  one_res = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: one_res = {{(DATA_WIDTH-1){1'b0}}, a < b};
            OP_LUI:  one_res = {b[DATA_WIDTH-13:0], 12'b0};
            OP_OR:   one_res = a | b;
            OP_SLL:  one_res = a << sh;
`ifdef ALU_MULDIV_EN
            // only selected when B is zero; nonzero divisors go iterative
            OP_DIVU: one_res = '1;
            OP_REMU: one_res = a;
`endif
            default: one_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    state_e                state_q, state_d;
    logic                  sel_hi_q, sel_hi_d, it_start, it_last, is_mul, is_div;
    logic [DATA_WIDTH-1:0] it_lo, it_hi;

    assign is_mul     = op == OP_MUL || op == OP_MULHU;
    assign is_div     = (op == OP_DIVU || op == OP_REMU) && b != '0;
    assign bus.Busy_o = state_q != S_IDLE;

    alu_iter_unit #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
        .clk     (clk),
        .reset   (reset),
        .start_i (it_start),
        .div_i   (~is_mul),
        .step_i  (state_q != S_IDLE),
        .a_i     (a),
        .b_i     (b),
        .last_o  (it_last),
        .lo_o    (it_lo),
        .hi_o    (it_hi)
    );

    always_comb begin
        state_d  = state_q;
        sel_hi_d = sel_hi_q;
        it_start = 1'b0;
        wr       = 1'b0;
        res_d    = one_res;
        if (state_q == S_IDLE) begin
            if (bus.Start_i && (is_mul || is_div)) begin
                it_start = 1'b1;
                state_d  = is_mul ? S_MUL : S_DIV;
                sel_hi_d = op == OP_MULHU || op == OP_REMU;
            end else begin
                wr = bus.Start_i;
            end
        end else if (it_last) begin
            wr      = 1'b1;
            res_d   = sel_hi_q ? it_hi : it_lo;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sel_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_hi_q <= sel_hi_d;
        end
    end
`else
    assign wr         = bus.Start_i;
    assign res_d      = one_res;
    assign bus.Busy_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q  <= '0;
            zero_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= wr;
            if (wr) begin
                res_q  <= res_d;
                zero_q <= res_d == '0;
            end
        end
    end

    assign bus.Done_o       = done_q;
    assign bus.Zero_o       = zero_q;
    assign bus.ALU_Result_o = res_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: randomized scoreboard bench for multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          launch;
        int          done_edge;
        bit          it;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    multicycle_alu_if #(.DATA_WIDTH(32), .OP_WIDTH(4)) bus ();
    multicycle_alu #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit it);
        logic [63:0] p;
        p  = {32'b0, a} * {32'b0, b};
        it = 1'b0;
        r  = 32'd0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a >> b[4:0];
            4'd4:  r = a ^ b;
            4'd5:  r = 32'($signed(a) >>> b[4:0]);
            4'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  r = (a < b) ? 32'd1 : 32'd0;
            4'd8:  r = b << 12;
            4'd9:  r = a | b;
            4'd12: r = a << b[4:0];
`ifdef ALU_MULDIV_EN
            4'd10: begin r = p[31:0];  it = 1'b1; end
            4'd11: begin r = p[63:32]; it = 1'b1; end
            4'd13: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; it = b != 0; end
            4'd14: begin r = (b == 0) ? a : a % b;             it = b != 0; end
`endif
            default: r = 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (q.size() > 0 && cyc >= q[0].launch) begin
                check("busy", 32'(bus.Busy_o), 32'(q[0].it && cyc < q[0].done_edge));
                if (bus.Done_o) begin
                    check("latency", cyc, q[0].done_edge);
                    check("result", bus.ALU_Result_o, q[0].res);
                    check("zero", 32'(bus.Zero_o), 32'(q[0].res == 0));
                    void'(q.pop_front());
                end else if (cyc >= q[0].done_edge + 2) begin
                    checks++;
                    errors++;
                    $display("FAIL done_timeout: no Done_o by cycle %0d, required at %0d", cyc, q[0].done_edge);
                    void'(q.pop_front());
                end
            end else begin
                check("spurious_done", 32'(bus.Done_o), 32'd0);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        bit          it;
        int          n;
        n = 0;
        while (bus.Busy_o && n < 200) begin
            bus.Start_i         = (n == 3) || ($urandom_range(0, 2) == 0);
            bus.ALU_Operation_i = OP_ADD;
            bus.A_i             = $urandom;
            bus.B_i             = $urandom;
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: Busy_o still 1 after %0d cycles, required 0", n);
        end
        model(op, a, b, r, it);
        bus.Start_i         = 1'b1;
        bus.ALU_Operation_i = op;
        bus.A_i             = a;
        bus.B_i             = b;
        q.push_back('{r, cyc + 1, cyc + 1 + (it ? 32 : 0), it});
        @(posedge clk);
        #1;
        bus.Start_i         = 1'b0;
        bus.ALU_Operation_i = 4'($urandom);
        bus.A_i             = $urandom;
        bus.B_i             = $urandom;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b;
        int n;
        bus.Start_i         = 1'b0;
        bus.ALU_Operation_i = '0;
        bus.A_i             = '0;
        bus.B_i             = '0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(bus.Busy_o), 32'd0);
        check("rst_done", 32'(bus.Done_o), 32'd0);
        check("rst_result", bus.ALU_Result_o, 32'd0);
        check("rst_zero", 32'(bus.Zero_o), 32'd1);

        issue(OP_ADD, 32'd5, 32'd7);
        issue(OP_SUB, 32'd7, 32'd7);
        issue(OP_LUI, 32'd0, 32'h0001_2345);
        issue(OP_SRA, 32'h8000_0000, 32'd4);
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        issue(OP_MUL, 32'hFFFF_FFFF, 32'd2);
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'd2);
        issue(OP_DIVU, 32'd100, 32'd7);
        issue(OP_REMU, 32'd100, 32'd7);
        issue(OP_DIVU, 32'd9, 32'd0);
        issue(OP_REMU, 32'd9, 32'd0);
        issue(4'b1111, 32'd3, 32'd4);
        issue(OP_MUL, 32'd3, 32'd4);

        // asynchronous reset in the middle of a multiply
        issue(OP_MUL, 32'hFFFF_FFFF, 32'd3);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.Busy_o), 32'd0);
        check("midrst_done", 32'(bus.Done_o), 32'd0);
        check("midrst_result", bus.ALU_Result_o, 32'd0);
        check("midrst_zero", 32'(bus.Zero_o), 32'd1);
        q.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        repeat (300) begin
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(4'($urandom_range(0, 15)), a, b);
        end

        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
